// File: rtl/relogio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : relogio_pkg
//  Description : Shared types, constants and helpers for the adjustable clock.
//  Revision    : 1.0 - initial release
// ============================================================================
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2
    } estado_t;

    // All segments off (segments are active-low).
    localparam logic [6:0] BLANK = 7'b1111111;

    // Converts a stored 24 h BCD hour into its 12 h BCD form {msd[1:0], lsd[3:0]}.
    function automatic logic [5:0] hora_24_para_12(input logic [1:0] h_msd,
                                                   input logic [3:0] h_lsd);
        logic [4:0] hora;
        logic [4:0] hora12;
        logic [1:0] msd;
        logic [3:0] lsd;
        hora = (5'(h_msd) * 5'd10) + 5'(h_lsd);
        if (hora == 5'd0) begin
            hora12 = 5'd12;
        end else if (hora > 5'd12) begin
            hora12 = hora - 5'd12;
        end else begin
            hora12 = hora;
        end
        if (hora12 >= 5'd10) begin
            msd = 2'd1;
            lsd = 4'(hora12 - 5'd10);
        end else begin
            msd = 2'd0;
            lsd = hora12[3:0];
        end
        return {msd, lsd};
    endfunction

endpackage
`default_nettype wire

// File: rtl/relogio_ajustavel_if.sv
`default_nettype none
// ============================================================================
//  Module      : relogio_ajustavel_if
//  Description : User controls and display outputs of the adjustable clock.
//  Revision    : 1.0 - initial release
// ============================================================================
interface relogio_ajustavel_if;

    logic       modo_24h;
    logic       btn_modo;
    logic       btn_inc;

    logic [6:0] s_lsd;
    logic [6:0] s_msd;
    logic [6:0] m_lsd;
    logic [6:0] m_msd;
    logic [6:0] h_lsd;
    logic [6:0] h_msd;

    logic [3:0] bcd_s_lsd;
    logic [2:0] bcd_s_msd;
    logic [3:0] bcd_m_lsd;
    logic [2:0] bcd_m_msd;
    logic [3:0] bcd_h_lsd;
    logic [1:0] bcd_h_msd;

    logic       pm;
    logic [1:0] estado;

    // Driver side: user controls out, display in.
    modport master (
        output modo_24h, btn_modo, btn_inc,
        input  s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd,
        input  bcd_s_lsd, bcd_s_msd, bcd_m_lsd, bcd_m_msd, bcd_h_lsd, bcd_h_msd,
        input  pm, estado
    );

    // Clock side: user controls in, display out.
    modport slave (
        input  modo_24h, btn_modo, btn_inc,
        output s_lsd, s_msd, m_lsd, m_msd, h_lsd, h_msd,
        output bcd_s_lsd, bcd_s_msd, bcd_m_lsd, bcd_m_msd, bcd_h_lsd, bcd_h_msd,
        output pm, estado
    );

endinterface
`default_nettype wire

// File: rtl/bcd_7seg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_7seg
//  Description : BCD digit to active-low seven-segment pattern {g,f,e,d,c,b,a}.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_7seg (
    input  wire logic [3:0] bcd,
    output logic      [6:0] seg
);

    // Pure lookup; codes above 9 turn every segment off.
    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/gerador_tick.sv
`default_nettype none
// ============================================================================
//  Module      : gerador_tick
//  Description : Divides the system clock into a one-second tick and a
//                half-period blink phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module gerador_tick #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clr,
    output logic      tick,
    output logic      blink_off
);

    localparam int              DIV_W      = $clog2(CLK_FREQ_HZ);
    localparam logic [DIV_W-1:0] C_DIV_MAX  = DIV_W'(CLK_FREQ_HZ - 1);
    localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(CLK_FREQ_HZ / 2);

    logic [DIV_W-1:0] r_div;

    // Free-running divider; clr restarts the second so the next tick is a full period away.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_div <= '0;
        end else if (clr || (r_div == C_DIV_MAX)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign tick      = (r_div == C_DIV_MAX);
    assign blink_off = (r_div >= C_DIV_HALF);

endmodule
`default_nettype wire

// File: rtl/relogio_ajustavel.sv
`default_nettype none
// ============================================================================
//  Module      : relogio_ajustavel
//  Description : Settable HH:MM:SS BCD clock with 12/24 h display, blinking
//                edit fields and seven-segment outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module relogio_ajustavel
    import relogio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  wire logic         clock,
    input  wire logic         reset,
    relogio_ajustavel_if.slave ifc
);

    estado_t    r_estado;
    estado_t    w_estado_nxt;

    logic [3:0] r_s_lsd, w_s_lsd_nxt;
    logic [2:0] r_s_msd, w_s_msd_nxt;
    logic [3:0] r_m_lsd, w_m_lsd_nxt;
    logic [2:0] r_m_msd, w_m_msd_nxt;
    logic [3:0] r_h_lsd, w_h_lsd_nxt;
    logic [1:0] r_h_msd, w_h_msd_nxt;

    logic       w_tick;
    logic       w_blink_off;
    logic       w_sai_set_m;
    logic       w_inc_aceito;

    logic       w_s_fim;
    logic       w_m_fim;
    logic       w_h_fim;

    logic [5:0] w_h12;
    logic [3:0] w_bcd_h_lsd;
    logic [1:0] w_bcd_h_msd;

    logic [6:0] w_seg_s_lsd, w_seg_s_msd;
    logic [6:0] w_seg_m_lsd, w_seg_m_msd;
    logic [6:0] w_seg_h_lsd, w_seg_h_msd;

    logic       w_blank_h;
    logic       w_blank_m;

    // Leaving SET_M restarts the current second from zero.
    assign w_sai_set_m  = (r_estado == SET_M) && ifc.btn_modo;
    // The mode button takes priority over the increment button.
    assign w_inc_aceito = ifc.btn_inc && !ifc.btn_modo;

    gerador_tick #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ)
    ) u_gerador_tick (
        .clock     (clock),
        .reset     (reset),
        .clr       (w_sai_set_m),
        .tick      (w_tick),
        .blink_off (w_blink_off)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= RUN;
        end else begin
            r_estado <= w_estado_nxt;
        end
    end

    // Mode button cycles RUN -> SET_H -> SET_M -> RUN.
    always_comb begin
        w_estado_nxt = r_estado;
        if (ifc.btn_modo) begin
            case (r_estado)
                RUN:     w_estado_nxt = SET_H;
                SET_H:   w_estado_nxt = SET_M;
                SET_M:   w_estado_nxt = RUN;
                default: w_estado_nxt = RUN;
            endcase
        end
    end

    assign w_s_fim = (r_s_msd == 3'd5) && (r_s_lsd == 4'd9);
    assign w_m_fim = (r_m_msd == 3'd5) && (r_m_lsd == 4'd9);
    assign w_h_fim = (r_h_msd == 2'd2) && (r_h_lsd == 4'd3);

    // Next stored time: tick counting in RUN, field edits in SET_H / SET_M.
    always_comb begin
        w_s_lsd_nxt = r_s_lsd;
        w_s_msd_nxt = r_s_msd;
        w_m_lsd_nxt = r_m_lsd;
        w_m_msd_nxt = r_m_msd;
        w_h_lsd_nxt = r_h_lsd;
        w_h_msd_nxt = r_h_msd;
        if ((r_estado == RUN) && w_tick) begin
            if (r_s_lsd != 4'd9) begin
                w_s_lsd_nxt = r_s_lsd + 4'd1;
            end else begin
                w_s_lsd_nxt = 4'd0;
                w_s_msd_nxt = (r_s_msd == 3'd5) ? 3'd0 : r_s_msd + 3'd1;
            end
            if (w_s_fim) begin
                if (r_m_lsd != 4'd9) begin
                    w_m_lsd_nxt = r_m_lsd + 4'd1;
                end else begin
                    w_m_lsd_nxt = 4'd0;
                    w_m_msd_nxt = (r_m_msd == 3'd5) ? 3'd0 : r_m_msd + 3'd1;
                end
                if (w_m_fim) begin
                    if (w_h_fim) begin
                        w_h_lsd_nxt = 4'd0;
                        w_h_msd_nxt = 2'd0;
                    end else if (r_h_lsd == 4'd9) begin
                        w_h_lsd_nxt = 4'd0;
                        w_h_msd_nxt = r_h_msd + 2'd1;
                    end else begin
                        w_h_lsd_nxt = r_h_lsd + 4'd1;
                    end
                end
            end
        end else if ((r_estado == SET_H) && w_inc_aceito) begin
            if (w_h_fim) begin
                w_h_lsd_nxt = 4'd0;
                w_h_msd_nxt = 2'd0;
            end else if (r_h_lsd == 4'd9) begin
                w_h_lsd_nxt = 4'd0;
                w_h_msd_nxt = r_h_msd + 2'd1;
            end else begin
                w_h_lsd_nxt = r_h_lsd + 4'd1;
            end
        end else if (w_sai_set_m) begin
            w_s_lsd_nxt = 4'd0;
            w_s_msd_nxt = 3'd0;
        end else if ((r_estado == SET_M) && w_inc_aceito) begin
            if (r_m_lsd != 4'd9) begin
                w_m_lsd_nxt = r_m_lsd + 4'd1;
            end else begin
                w_m_lsd_nxt = 4'd0;
                w_m_msd_nxt = (r_m_msd == 3'd5) ? 3'd0 : r_m_msd + 3'd1;
            end
        end
    end

    // Stored time registers (always 24 h BCD).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s_lsd <= 4'd0;
            r_s_msd <= 3'd0;
            r_m_lsd <= 4'd0;
            r_m_msd <= 3'd0;
            r_h_lsd <= 4'd0;
            r_h_msd <= 2'd0;
        end else begin
            r_s_lsd <= w_s_lsd_nxt;
            r_s_msd <= w_s_msd_nxt;
            r_m_lsd <= w_m_lsd_nxt;
            r_m_msd <= w_m_msd_nxt;
            r_h_lsd <= w_h_lsd_nxt;
            r_h_msd <= w_h_msd_nxt;
        end
    end

    // Display mapping: only the shown hour depends on the 12/24 h mode.
    assign w_h12       = hora_24_para_12(r_h_msd, r_h_lsd);
    assign w_bcd_h_msd = ifc.modo_24h ? r_h_msd : w_h12[5:4];
    assign w_bcd_h_lsd = ifc.modo_24h ? r_h_lsd : w_h12[3:0];

    assign ifc.bcd_s_lsd = r_s_lsd;
    assign ifc.bcd_s_msd = r_s_msd;
    assign ifc.bcd_m_lsd = r_m_lsd;
    assign ifc.bcd_m_msd = r_m_msd;
    assign ifc.bcd_h_lsd = w_bcd_h_lsd;
    assign ifc.bcd_h_msd = w_bcd_h_msd;

    assign ifc.pm     = (r_h_msd == 2'd2) || ((r_h_msd == 2'd1) && (r_h_lsd >= 4'd2));
    assign ifc.estado = r_estado;

    bcd_7seg u_dec_s_lsd (.bcd(r_s_lsd),              .seg(w_seg_s_lsd));
    bcd_7seg u_dec_s_msd (.bcd({1'b0, r_s_msd}),      .seg(w_seg_s_msd));
    bcd_7seg u_dec_m_lsd (.bcd(r_m_lsd),              .seg(w_seg_m_lsd));
    bcd_7seg u_dec_m_msd (.bcd({1'b0, r_m_msd}),      .seg(w_seg_m_msd));
    bcd_7seg u_dec_h_lsd (.bcd(w_bcd_h_lsd),          .seg(w_seg_h_lsd));
    bcd_7seg u_dec_h_msd (.bcd({2'b00, w_bcd_h_msd}), .seg(w_seg_h_msd));

    // The field being edited blanks during the second half of each second.
    assign w_blank_h = (r_estado == SET_H) && w_blink_off;
    assign w_blank_m = (r_estado == SET_M) && w_blink_off;

    assign ifc.s_lsd = w_seg_s_lsd;
    assign ifc.s_msd = w_seg_s_msd;
    assign ifc.m_lsd = w_blank_m ? BLANK : w_seg_m_lsd;
    assign ifc.m_msd = w_blank_m ? BLANK : w_seg_m_msd;
    assign ifc.h_lsd = w_blank_h ? BLANK : w_seg_h_lsd;
    assign ifc.h_msd = w_blank_h ? BLANK : w_seg_h_msd;

endmodule
`default_nettype wire

// File: tb/tb_relogio_ajustavel.sv
`default_nettype none
// ============================================================================
//  Module      : tb_relogio_ajustavel
//  Description : Self-checking bench for relogio_ajustavel against a
//                seconds-of-day reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_relogio_ajustavel;

    localparam int F = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    relogio_ajustavel_if ifc ();

    relogio_ajustavel #(
        .CLK_FREQ_HZ (F)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ifc   (ifc)
    );

    always #5 clock = ~clock;

    // Reference model: time as seconds of day, state as 0/1/2, divider phase.
    int m_t;
    int m_state;
    int m_div;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    bit drv_modo;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int disp_hour(input int h, input bit md);
        if (md) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_reset();
        m_t = 0;
        m_state = 0;
        m_div = 0;
    endtask

    // One rising edge of the model, with the buttons that were presented.
    task automatic model_clock(input bit bm, input bit bi);
        bit tick;
        bit clr;
        int h;
        int mi;
        if (reset) begin
            model_reset();
            return;
        end
        tick = (m_div == F - 1);
        clr  = 1'b0;
        if (m_state == 0 && tick) m_t = (m_t + 1) % 86400;
        if (bm) begin
            if (m_state == 2) begin
                m_t = m_t - (m_t % 60);
                clr = 1'b1;
            end
            m_state = (m_state + 1) % 3;
        end else if (bi) begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            if (m_state == 1) m_t = m_t + (((h + 1) % 24) - h) * 3600;
            if (m_state == 2) m_t = m_t + (((mi + 1) % 60) - mi) * 60;
        end
        m_div = clr ? 0 : (m_div + 1) % F;
    endtask

    task automatic compare_all();
        int h, mi, s, dh;
        bit bh, bmin;
        h    = m_t / 3600;
        mi   = (m_t / 60) % 60;
        s    = m_t % 60;
        dh   = disp_hour(h, drv_modo);
        bh   = (m_state == 1) && (m_div >= F / 2);
        bmin = (m_state == 2) && (m_div >= F / 2);
        check_value("estado",    32'(ifc.estado),    32'(m_state));
        check_value("pm",        32'(ifc.pm),        32'(h >= 12));
        check_value("bcd_s_lsd", 32'(ifc.bcd_s_lsd), 32'(s % 10));
        check_value("bcd_s_msd", 32'(ifc.bcd_s_msd), 32'(s / 10));
        check_value("bcd_m_lsd", 32'(ifc.bcd_m_lsd), 32'(mi % 10));
        check_value("bcd_m_msd", 32'(ifc.bcd_m_msd), 32'(mi / 10));
        check_value("bcd_h_lsd", 32'(ifc.bcd_h_lsd), 32'(dh % 10));
        check_value("bcd_h_msd", 32'(ifc.bcd_h_msd), 32'(dh / 10));
        check_value("seg_s_lsd", 32'(ifc.s_lsd), 32'(seg_tab[s % 10]));
        check_value("seg_s_msd", 32'(ifc.s_msd), 32'(seg_tab[s / 10]));
        check_value("seg_m_lsd", 32'(ifc.m_lsd), bmin ? 32'h7f : 32'(seg_tab[mi % 10]));
        check_value("seg_m_msd", 32'(ifc.m_msd), bmin ? 32'h7f : 32'(seg_tab[mi / 10]));
        check_value("seg_h_lsd", 32'(ifc.h_lsd), bh ? 32'h7f : 32'(seg_tab[dh % 10]));
        check_value("seg_h_msd", 32'(ifc.h_msd), bh ? 32'h7f : 32'(seg_tab[dh / 10]));
    endtask

    // Called just after a falling edge: drive, compare, clock, return on next falling edge.
    task automatic step(input bit bm, input bit bi, input bit md);
        ifc.btn_modo = bm;
        ifc.btn_inc  = bi;
        ifc.modo_24h = md;
        drv_modo     = md;
        #1;
        compare_all();
        @(posedge clock);
        model_clock(bm, bi);
        @(negedge clock);
    endtask

    initial begin
        ifc.btn_modo = 1'b0;
        ifc.btn_inc  = 1'b0;
        ifc.modo_24h = 1'b1;
        drv_modo     = 1'b1;
        model_reset();
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);

        // Reset state in both display modes.
        #1;
        compare_all();
        ifc.modo_24h = 1'b0;
        drv_modo     = 1'b0;
        #1;
        compare_all();
        check_value("rst_h12_msd", 32'(ifc.bcd_h_msd), 32'd1);
        check_value("rst_h12_lsd", 32'(ifc.bcd_h_lsd), 32'd2);
        @(negedge clock);
        reset = 1'b0;

        // First tick lands on the 4th cycle after release.
        repeat (4) step(1'b0, 1'b0, 1'b1);
        check_value("first_sec", 32'(ifc.bcd_s_lsd), 32'd1);
        repeat (236) step(1'b0, 1'b0, 1'b1);
        check_value("one_min_m", 32'(ifc.bcd_m_lsd), 32'd1);
        check_value("one_min_s", 32'(ifc.bcd_s_lsd), 32'd0);

        // Preload 23:59:00, run to 23:59:59 then roll over.
        step(1'b1, 1'b0, 1'b1);
        repeat (23) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        repeat (58) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        check_value("pre_h_msd", 32'(ifc.bcd_h_msd), 32'd2);
        check_value("pre_h_lsd", 32'(ifc.bcd_h_lsd), 32'd3);
        check_value("pre_m_msd", 32'(ifc.bcd_m_msd), 32'd5);
        repeat (236) step(1'b0, 1'b0, 1'b1);
        check_value("at_59s", 32'(ifc.bcd_s_msd), 32'd5);
        repeat (4) step(1'b0, 1'b0, 1'b1);
        check_value("roll_h", 32'(ifc.bcd_h_lsd), 32'd0);
        check_value("roll_m", 32'(ifc.bcd_m_msd), 32'd0);
        check_value("roll_pm", 32'(ifc.pm), 32'd0);

        // 25 hour increments wrap to 01 without touching minutes.
        step(1'b1, 1'b0, 1'b1);
        repeat (25) step(1'b0, 1'b1, 1'b1);
        check_value("seth_estado", 32'(ifc.estado), 32'd1);
        check_value("seth_h_lsd", 32'(ifc.bcd_h_lsd), 32'd1);
        check_value("seth_m_lsd", 32'(ifc.bcd_m_lsd), 32'd0);

        // Mode and increment together in SET_M: leave, minute unchanged.
        step(1'b1, 1'b0, 1'b1);
        repeat (7) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check_value("both_estado", 32'(ifc.estado), 32'd0);
        check_value("both_m_lsd", 32'(ifc.bcd_m_lsd), 32'd7);
        check_value("both_s_lsd", 32'(ifc.bcd_s_lsd), 32'd0);

        // 12 h display: 13 -> 01 PM, 00 -> 12 AM.
        step(1'b1, 1'b0, 1'b0);
        repeat (12) step(1'b0, 1'b1, 1'b0);
        check_value("h13_msd", 32'(ifc.bcd_h_msd), 32'd0);
        check_value("h13_lsd", 32'(ifc.bcd_h_lsd), 32'd1);
        check_value("h13_pm", 32'(ifc.pm), 32'd1);
        repeat (11) step(1'b0, 1'b1, 1'b0);
        check_value("h0_msd", 32'(ifc.bcd_h_msd), 32'd1);
        check_value("h0_lsd", 32'(ifc.bcd_h_lsd), 32'd2);
        check_value("h0_pm", 32'(ifc.pm), 32'd0);

        // Asynchronous reset in the middle of SET_M.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_value("arst_estado", 32'(ifc.estado), 32'd0);
        check_value("arst_m_lsd", 32'(ifc.bcd_m_lsd), 32'd0);
        check_value("arst_h_lsd", 32'(ifc.bcd_h_lsd), 32'd2);
        model_reset();
        @(negedge clock);
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            bit bm, bi, md, rs;
            bm = ($urandom_range(0, 19) == 0);
            bi = ($urandom_range(0, 3) == 0);
            md = ($urandom_range(0, 49) == 0) ? ~drv_modo : drv_modo;
            rs = ($urandom_range(0, 499) == 0);
            if (rs) begin
                reset = 1'b1;
                model_reset();
            end
            step(bm, bi, md);
            reset = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
